// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: write-back source/load-type encodings and the W-register layout
package wb_stage_pkg;
  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC8 = 2'd2;
  localparam logic [1:0] WSEL_MDU = 2'd3;
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] mdu;
    logic [31:0] rdata;
  } w_reg_t;
endpackage

// File: rtl/wb_stage_load_ext.sv
// wb_stage_load_ext: picks the addressed byte/halfword of a load word and extends it to 32 bits
module wb_stage_load_ext
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] ext_data
);
  logic [31:0] sh;
  logic [15:0] h;
  logic [7:0]  b;
  // lane select then extension; halfwords ignore addr_lo[0], reserved types read as zero
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    b = sh[7:0];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_data = (ld_type == LD_LW)  ? rdata :
               (ld_type == LD_LH)  ? {{16{h[15]}}, h} :
               (ld_type == LD_LHU) ? {16'h0, h} :
               (ld_type == LD_LB)  ? {{24{b[7]}}, b} :
               (ld_type == LD_LBU) ? {24'h0, b} : 32'h0;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register, write-back source mux and register-file write port
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_we,
  input  logic [4:0]  m_waddr,
  input  logic [1:0]  m_wsel,
  input  logic [2:0]  m_ld_type,
  input  logic [1:0]  m_addr_lo,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_mdu,
  input  logic [31:0] m_rdata,
  input  logic        w_stall,
  input  logic        w_flush,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_pc,
  output logic        w_valid
);
  w_reg_t w_d, w_q, m_in;
  logic [31:0] ext_data;
  wb_stage_load_ext u_load_ext (
    .rdata    (w_q.rdata),
    .addr_lo  (w_q.addr_lo),
    .ld_type  (w_q.ld_type),
    .ext_data (ext_data)
  );
  // next W contents: reset beats flush beats stall; a bubble still tracks the M-stage pc
  always_comb begin
    m_in = {m_valid, m_pc, m_we, m_waddr, m_wsel, m_ld_type, m_addr_lo, m_alu, m_mdu, m_rdata};
    w_d = reset   ? '{pc: RESET_PC, default: '0} :
          w_flush ? '{pc: m_pc, default: '0} :
          w_stall ? w_q : m_in;
  end
  // M/W boundary register
  always_ff @(posedge clk) w_q <= w_d;
  // write port driven only from W state, so no combinational path from the m_* inputs
  always_comb begin
    grf_we = w_q.valid & w_q.we & (w_q.waddr != 5'd0);
    grf_waddr = w_q.waddr;
    grf_pc = w_q.pc;
    w_valid = w_q.valid;
    grf_wdata = (w_q.wsel == WSEL_ALU) ? w_q.alu :
                (w_q.wsel == WSEL_MEM) ? ext_data :
                (w_q.wsel == WSEL_PC8) ? w_q.pc + 32'd8 : w_q.mdu;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors and multi-cycle sequences for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, m_valid, m_we, w_stall, w_flush;
  logic [31:0] m_pc, m_alu, m_mdu, m_rdata;
  logic [4:0]  m_waddr;
  logic [1:0]  m_wsel, m_addr_lo;
  logic [2:0]  m_ld_type;
  logic        grf_we, w_valid;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata, grf_pc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] mdu;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt[13];

  wb_stage dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we),
    .m_waddr(m_waddr), .m_wsel(m_wsel), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
    .m_alu(m_alu), .m_mdu(m_mdu), .m_rdata(m_rdata), .w_stall(w_stall), .w_flush(w_flush),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
    .w_valid(w_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_we, input logic [4:0] e_waddr,
                           input logic [31:0] e_wdata, input logic [31:0] e_pc, input logic e_valid);
    chk({tag, ".we"}, {31'h0, grf_we}, {31'h0, e_we});
    chk({tag, ".waddr"}, {27'h0, grf_waddr}, {27'h0, e_waddr});
    chk({tag, ".wdata"}, grf_wdata, e_wdata);
    chk({tag, ".pc"}, grf_pc, e_pc);
    chk({tag, ".valid"}, {31'h0, w_valid}, {31'h0, e_valid});
  endtask

  task automatic drive(input vec_t v);
    m_valid = v.valid; m_pc = v.pc; m_we = v.we; m_waddr = v.waddr; m_wsel = v.wsel;
    m_ld_type = v.ld; m_addr_lo = v.lo; m_alu = v.alu; m_mdu = v.mdu; m_rdata = v.rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t a, b;
    //          valid pc            we    waddr  wsel  ld    lo    alu            mdu            rdata          e_we  e_wdata
    vt[0]  = '{1'b1, 32'h0000_3004, 1'b1, 5'd5,  2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'h1234_5678};
    vt[1]  = '{1'b1, 32'h0000_3008, 1'b1, 5'd0,  2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0,         32'h0,         1'b0, 32'h1234_5678};
    vt[2]  = '{1'b1, 32'h0000_300C, 1'b1, 5'd7,  2'd1, 3'd3, 2'd3, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'hFFFF_FF80};
    vt[3]  = '{1'b1, 32'h0000_3010, 1'b1, 5'd8,  2'd1, 3'd4, 2'd1, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_007F};
    vt[4]  = '{1'b1, 32'h0000_3014, 1'b1, 5'd9,  2'd1, 3'd1, 2'd2, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    vt[5]  = '{1'b1, 32'h0000_3018, 1'b1, 5'd10, 2'd1, 3'd2, 2'd0, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_7F01};
    vt[6]  = '{1'b1, 32'h0000_301C, 1'b1, 5'd11, 2'd1, 3'd0, 2'd2, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'h80FF_7F01};
    vt[7]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0,         32'h0,         32'h0,         1'b1, 32'h0000_0004};
    vt[8]  = '{1'b1, 32'h0000_3020, 1'b1, 5'd3,  2'd3, 3'd0, 2'd0, 32'h1111_1111, 32'hCAFE_BABE, 32'h0,         1'b1, 32'hCAFE_BABE};
    vt[9]  = '{1'b1, 32'h0000_3024, 1'b1, 5'd12, 2'd1, 3'd5, 2'd0, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_0000};
    vt[10] = '{1'b0, 32'h0000_3028, 1'b1, 5'd4,  2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0,         32'h0,         1'b0, 32'hAAAA_5555};
    vt[11] = '{1'b1, 32'h0000_302C, 1'b1, 5'd13, 2'd1, 3'd3, 2'd0, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_0001};
    vt[12] = '{1'b1, 32'h0000_3030, 1'b1, 5'd14, 2'd1, 3'd1, 2'd3, 32'h0,         32'h0,         32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    a = '{1'b1, 32'h0000_3100, 1'b1, 5'd31, 2'd3, 3'd0, 2'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF};
    b = '{1'b1, 32'h0000_3104, 1'b1, 5'd2,  2'd0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D};

    reset = 1'b1; w_stall = 1'b0; w_flush = 1'b0;
    drive(vt[0]);
    step();
    step();
    check_out("reset", 1'b0, 5'd0, 32'h0, 32'h0000_3000, 1'b0);
    reset = 1'b0;
    drive('{1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
    step();
    check_out("idle", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      step();
      check_out($sformatf("vec%0d", i), vt[i].e_we, vt[i].waddr, vt[i].e_wdata, vt[i].pc, vt[i].valid);
    end

    drive(vt[0]);
    w_flush = 1'b1;
    step();
    check_out("flush", 1'b0, 5'd0, 32'h0, 32'h0000_3004, 1'b0);
    drive(vt[8]);
    w_stall = 1'b1;
    step();
    check_out("flush_stall", 1'b0, 5'd0, 32'h0, 32'h0000_3020, 1'b0);
    w_flush = 1'b0; w_stall = 1'b0;

    drive(a);
    step();
    check_out("stall_load", 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0000_3100, 1'b1);
    drive(b);
    w_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall%0d", i), 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0000_3100, 1'b1);
    end
    w_stall = 1'b0;
    step();
    check_out("stall_release", 1'b1, 5'd2, 32'h0BAD_F00D, 32'h0000_3104, 1'b1);

    drive(a);
    reset = 1'b1; w_flush = 1'b1; w_stall = 1'b1;
    step();
    check_out("reset_mid", 1'b0, 5'd0, 32'h0, 32'h0000_3000, 1'b0);
    reset = 1'b0; w_flush = 1'b0; w_stall = 1'b0;
    step();
    check_out("after_reset", 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0000_3100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline. It registers the memory-stage (M) result bundle at the M/W boundary, extends load data to 32 bits, selects the write-back source and drives the register file write port (enable, address, data, PC for the write log). It is the only writer of the register file. The register file's same-cycle write-to-read bypass covers W-stage forwarding, so this block has no forwarding outputs beyond the write port itself.

## Interface
- RESET_PC, 32'h0000_3000, value of the W-stage PC register after reset.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m_valid  in  1  M stage holds a real instruction
- m_pc  in  32  PC of the M-stage instruction
- m_we  in  1  instruction writes a GPR
- m_waddr  in  5  destination GPR
- m_wsel  in  2  write-back source: 0 ALU, 1 MEM, 2 PC+8, 3 MDU
- m_ld_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5–7 reserved
- m_addr_lo  in  2  data address bits [1:0]
- m_alu  in  32  ALU result
- m_mdu  in  32  HI/LO read value
- m_rdata  in  32  data-memory read word, aligned
- w_stall  in  1  hold W contents
- w_flush  in  1  insert a bubble into W, e.g. on an exception at M
- grf_we  out  1  register file write enable
- grf_waddr  out  5  register file write address
- grf_wdata  out  32  register file write data
- grf_pc  out  32  PC of the writing instruction
- w_valid  out  1  W holds a real instruction, for the hazard unit

## Operation
- The W register holds valid, pc, we, waddr, wsel, ld_type, addr_lo, alu, mdu and rdata.
- Update priority at each posedge:
  - reset: all fields 0, pc = RESET_PC.
  - else w_flush: bubble. All fields 0 except pc, which loads m_pc.
  - else w_stall: all fields hold.
  - else: all fields load from the m_* inputs.
- grf_we = valid & we & (waddr != 0). Writes to $0 never assert grf_we.
- grf_waddr = waddr and grf_pc = pc, passed through unconditionally.
- grf_wdata depends on wsel:
  - ALU: alu
  - MEM: extended load data
  - PC+8: pc + 8, 32-bit modulo wrap
  - MDU: mdu
- Load extension:
  - LW: rdata; addr_lo is ignored.
  - LH/LHU: halfword rdata[16*addr_lo[1] +: 16], sign- or zero-extended; addr_lo[0] is ignored.
  - LB/LBU: byte rdata[8*addr_lo +: 8], sign- or zero-extended.
  - Reserved ld_type: 32'h0.
- Misaligned accesses are not detected here. The exception unit flushes them through w_flush.

## Timing
- One-cycle latency. Inputs presented in cycle n appear on grf_* during cycle n+1, and the register file commits at the end of n+1.
- All grf_* outputs are combinational from the W register only, with no paths from the m_* inputs. This prevents an M→GRF combinational loop.
- Reset values: grf_we 0, grf_waddr 0, grf_wdata 0, grf_pc RESET_PC, w_valid 0.
- Flush and stall together: flush wins and a bubble is inserted.
- Reset together with flush or stall: reset wins.
- During stall: grf_we stays asserted with identical address and data, so the register file rewrites the same value. This is idempotent. The hazard unit must not stall W and upstream stages inconsistently.
- Reset mid-operation: the pending instruction in W is discarded and no write occurs in the following cycle.

## Structure
- Shared package holds the WSEL_* (2-bit) and LD_* (3-bit) constants; the decoder uses the same definitions.
- One sub-module, load_ext: a combinational unit with inputs rdata, addr_lo and ld_type, and output ext_data.
- The top level contains the W register, the source mux and the write-enable logic.

## Test plan
- Reset, then idle: grf_we=0, grf_wdata=0, grf_pc=32'h0000_3000.
- ALU write of 32'h1234_5678 to $5 at pc 32'h3004: the next cycle shows grf_we=1, waddr=5, wdata=32'h1234_5678, pc=32'h3004. With waddr=0, grf_we=0.
- MEM path with rdata=32'h80FF_7F01:
  - LB, addr_lo=3: wdata FFFF_FF80.
  - LBU, addr_lo=1: 0000_007F.
  - LH, addr_lo=2: FFFF_80FF.
  - LHU, addr_lo=0: 0000_7F01.
  - LW: 80FF_7F01.
- PC+8 (jal) at pc 32'hFFFF_FFFC: wdata 32'h0000_0004.
- Flush with valid write inputs: next cycle grf_we=0, waddr=0, grf_pc=m_pc. Flush with stall asserted together: bubble.
- Stall for 3 cycles holding an MDU write of 32'hDEAD_BEEF to $31: outputs are constant for 3 cycles, then load new inputs on the first cycle after stall drops.
